// File: rtl/fft_radix2_iter.sv
// fft_radix2_iter: iterative in-place radix-2 DIT FFT, serial load/unload, 1/N scaling.
// Define FFT_INVERSE_EN to let `inv` conjugate the twiddles (inverse transform).
module fft_radix2_iter #(
    parameter int W = 16,
    parameter int N = 16,
    parameter TWIDDLE_FILE = "twiddle_q15.hex"
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                inv,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic signed [W-1:0] in_re,
    input  logic signed [W-1:0] in_im,
    output logic                out_valid,
    input  logic                out_ready,
    output logic signed [W-1:0] out_re,
    output logic signed [W-1:0] out_im,
    output logic                out_last,
    output logic                busy
);
    localparam int LOGN = $clog2(N);
    localparam int SW = $clog2(LOGN);
    localparam int P = 2 * W + 1;
    localparam int V = W + 3;
    localparam logic [1:0] S_LOAD = 2'd0, S_COMPUTE = 2'd1, S_UNLOAD = 2'd2;
    localparam logic [LOGN:0] CNT_LAST = (LOGN + 1)'(N - 1);
    localparam logic [SW-1:0] ST_LAST = SW'(LOGN - 1);
    localparam logic [LOGN-2:0] BF_LAST = '1;
    localparam logic signed [P-1:0] RND = P'(1) <<< (W - 2);
    localparam logic signed [V-1:0] MAXV = V'((1 <<< (W - 1)) - 1);
    localparam logic signed [V-1:0] MINV = V'(-(1 <<< (W - 1)));
    localparam longint PI30 = 64'sd3373259426;
    // Twiddles are generated at elaboration, so no image file is needed to build.
    localparam unused_tw_file = TWIDDLE_FILE;

    function automatic logic [2*W-1:0] twiddle(input longint k);
        longint th, x2, term, c, s, cq, sq, lim;
        logic neg;
        th = (64'sd2 * PI30 * k) / longint'(N);
        neg = th > PI30 / 64'sd2;
        if (neg) th = PI30 - th;
        x2 = (th * th) >>> 30;
        term = 64'sd1 <<< 30;
        c = term;
        for (longint n = 2; n <= 16; n += 2) begin
            term = -((term * x2) >>> 30) / (n * (n - 1));
            c += term;
        end
        term = th;
        s = th;
        for (longint n = 3; n <= 17; n += 2) begin
            term = -((term * x2) >>> 30) / (n * (n - 1));
            s += term;
        end
        lim = (64'sd1 <<< (W - 1)) - 64'sd1;
        cq = (c + (64'sd1 <<< (30 - W))) >>> (31 - W);
        sq = (s + (64'sd1 <<< (30 - W))) >>> (31 - W);
        cq = cq > lim ? lim : cq;
        sq = sq > lim ? lim : sq;
        if (neg) cq = -cq;
        return {cq[W-1:0], sq[W-1:0]};
    endfunction

    function automatic logic [LOGN-1:0] bitrev(input logic [LOGN-1:0] v);
        logic [LOGN-1:0] r;
        for (int i = 0; i < LOGN; i++) r[i] = v[LOGN-1-i];
        return r;
    endfunction

    function automatic logic signed [W-1:0] sat(input logic signed [V-1:0] v);
        return (v > MAXV) ? MAXV[W-1:0] : (v < MINV) ? MINV[W-1:0] : v[W-1:0];
    endfunction

    logic [2*W-1:0] tw_rom [N/2];
    for (genvar i = 0; i < N / 2; i++) begin : g_tw
        localparam logic [2*W-1:0] TW = twiddle(longint'(i));
        assign tw_rom[i] = TW;
    end

    logic [1:0] state_q, state_d;
    logic [LOGN:0] cnt_q, cnt_d;
    logic [SW-1:0] stage_q, stage_d;
    logic [LOGN-2:0] bfly_q, bfly_d;
    logic signed [W-1:0] mem_re_q [N];
    logic signed [W-1:0] mem_im_q [N];
    logic in_fire;
    logic [LOGN-1:0] j, half, p, a_idx, b_idx;
    logic [LOGN-2:0] tw_idx;
    logic [2*W-1:0] tw;
    logic signed [W-1:0] ar, ai, br, bi, c, s, se, na_re, na_im, nb_re, nb_im;
    logic signed [P-1:0] pr, pi;
    logic signed [W+1:0] tr, ti;
    logic signed [V-1:0] sa_re, sa_im, sb_re, sb_im;

`ifdef FFT_INVERSE_EN
    logic inv_q, inv_d;
    assign inv_d = (in_fire && cnt_q == '0) ? inv : inv_q;
    assign se = inv_q ? -s : s;
    always_ff @(posedge clk) begin
        if (rst) inv_q <= 1'b0;
        else inv_q <= inv_d;
    end
`else
    logic unused_inv;
    assign unused_inv = inv;
    assign se = s;
`endif

    assign in_ready = state_q == S_LOAD;
    assign out_valid = state_q == S_UNLOAD;
    assign busy = state_q != S_LOAD;
    assign in_fire = in_valid && in_ready;
    assign out_last = out_valid && cnt_q == CNT_LAST;
    assign out_re = out_valid ? mem_re_q[cnt_q[LOGN-1:0]] : '0;
    assign out_im = out_valid ? mem_im_q[cnt_q[LOGN-1:0]] : '0;

    // Butterfly j of stage s pairs a = (group << (s+1)) | pos with b = a + 2^s.
    always_comb begin
        j = {1'b0, bfly_q};
        half = LOGN'(1) << stage_q;
        p = j & (half - LOGN'(1));
        a_idx = ((j & ~(half - LOGN'(1))) << 1) | p;
        b_idx = a_idx | half;
        tw_idx = (LOGN - 1)'({p, {(LOGN - 1){1'b0}}} >> stage_q);
        tw = tw_rom[tw_idx];
        c = signed'(tw[2*W-1:W]);
        s = signed'(tw[W-1:0]);
        ar = mem_re_q[a_idx];
        ai = mem_im_q[a_idx];
        br = mem_re_q[b_idx];
        bi = mem_im_q[b_idx];
        pr = P'(br) * P'(c) + P'(bi) * P'(se);
        pi = P'(bi) * P'(c) - P'(br) * P'(se);
        tr = (W + 2)'((pr + RND) >>> (W - 1));
        ti = (W + 2)'((pi + RND) >>> (W - 1));
        sa_re = V'(ar) + V'(tr);
        sa_im = V'(ai) + V'(ti);
        sb_re = V'(ar) - V'(tr);
        sb_im = V'(ai) - V'(ti);
        na_re = sat(sa_re >>> 1);
        na_im = sat(sa_im >>> 1);
        nb_re = sat(sb_re >>> 1);
        nb_im = sat(sb_im >>> 1);
    end

    always_comb begin
        state_d = state_q;
        cnt_d = cnt_q;
        stage_d = stage_q;
        bfly_d = bfly_q;
        if (state_q == S_LOAD && in_valid) begin
            cnt_d = cnt_q == CNT_LAST ? '0 : cnt_q + 1'b1;
            state_d = cnt_q == CNT_LAST ? S_COMPUTE : S_LOAD;
        end else if (state_q == S_COMPUTE) begin
            bfly_d = bfly_q + 1'b1;
            if (bfly_q == BF_LAST) begin
                stage_d = stage_q == ST_LAST ? '0 : stage_q + 1'b1;
                state_d = stage_q == ST_LAST ? S_UNLOAD : S_COMPUTE;
            end
        end else if (state_q == S_UNLOAD && out_ready) begin
            cnt_d = cnt_q == CNT_LAST ? '0 : cnt_q + 1'b1;
            state_d = cnt_q == CNT_LAST ? S_LOAD : S_UNLOAD;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_LOAD;
            cnt_q <= '0;
            stage_q <= '0;
            bfly_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q <= cnt_d;
            stage_q <= stage_d;
            bfly_q <= bfly_d;
        end
    end

    always_ff @(posedge clk) begin
        if (in_fire) begin
            mem_re_q[bitrev(cnt_q[LOGN-1:0])] <= in_re;
            mem_im_q[bitrev(cnt_q[LOGN-1:0])] <= in_im;
        end else if (state_q == S_COMPUTE) begin
            mem_re_q[a_idx] <= na_re;
            mem_im_q[a_idx] <= na_im;
            mem_re_q[b_idx] <= nb_re;
            mem_im_q[b_idx] <= nb_im;
        end
    end
endmodule

// File: tb/tb_fft_radix2_iter.sv
// tb_fft_radix2_iter: directed frames for the iterative FFT with table-driven bin checks.
module tb_fft_radix2_iter;
    localparam int W = 16;
    localparam int N = 16;
    localparam real TWO_PI = 6.283185307179586;
`ifdef FFT_INVERSE_EN
    localparam int INV_BIN = 15;
`else
    localparam int INV_BIN = 1;
`endif

    typedef struct {
        int frame;
        int bin;
        int exp_re;
        int exp_im;
        int tol;
    } vec_t;

    logic clk = 1'b0, rst = 1'b1, inv = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
    logic signed [W-1:0] in_re = '0, in_im = '0;
    logic in_ready, out_valid, out_last, busy;
    logic signed [W-1:0] out_re, out_im;

    int checks = 0, failures = 0;
    int smp_re[N], smp_im[N];
    int cap_re[N], cap_im[N];
    int cap_last[N];
    int cap_n;
    int res_re[4][N], res_im[4][N];
    vec_t vecs[16];

    fft_radix2_iter #(.W(W), .N(N)) dut (
        .clk(clk), .rst(rst), .inv(inv),
        .in_valid(in_valid), .in_ready(in_ready), .in_re(in_re), .in_im(in_im),
        .out_valid(out_valid), .out_ready(out_ready), .out_re(out_re), .out_im(out_im),
        .out_last(out_last), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp, input int tol);
        checks++;
        if (act < exp - tol || act > exp + tol) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (tol %0d)", name, act, exp, tol);
        end
    endtask

    // kind 0: impulse of 16384 at pos; 1: DC 16384; 2: tone 8192*e^{j2pi n/16}
    task automatic make_frame(input int kind, input int pos);
        real ph;
        for (int n = 0; n < N; n++) begin
            ph = TWO_PI * n / N;
            smp_re[n] = kind == 0 ? (n == pos ? 16384 : 0) : kind == 1 ? 16384 : $rtoi($floor(8192.0 * $cos(ph) + 0.5));
            smp_im[n] = kind == 2 ? $rtoi($floor(8192.0 * $sin(ph) + 0.5)) : 0;
        end
    endtask

    task automatic drive_load(input bit inv_v);
        for (int n = 0; n < N; n++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_re = 16'(smp_re[n]);
            in_im = 16'(smp_im[n]);
            inv = n == 0 ? inv_v : !inv_v;
        end
    endtask

    task automatic run_frame(input bit inv_v, input bit bp, output int lat);
        int budget;
        bit stalled;
        int h_re, h_im, h_last;
        drive_load(inv_v);
        @(negedge clk);
        in_re = 16'sh5a5a;
        in_im = -16'sh1234;
        lat = 1;
        while (!out_valid && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        in_valid = 1'b0;
        check("no_in_ready_in_unload", int'(in_ready), 0, 0);
        cap_n = 0;
        stalled = 1'b0;
        budget = 0;
        h_re = 0; h_im = 0; h_last = 0;
        while (cap_n < N && budget < 2000) begin
            if (stalled) begin
                check("hold_re", int'(out_re), h_re, 0);
                check("hold_im", int'(out_im), h_im, 0);
                check("hold_last", int'(out_last), h_last, 0);
            end
            out_ready = bp ? ($urandom_range(0, 9) < 3) : 1'b1;
            if (out_valid && out_ready) begin
                cap_re[cap_n] = int'(out_re);
                cap_im[cap_n] = int'(out_im);
                cap_last[cap_n] = int'(out_last);
                cap_n++;
            end
            stalled = out_valid && !out_ready;
            h_re = int'(out_re);
            h_im = int'(out_im);
            h_last = int'(out_last);
            @(negedge clk);
            budget++;
        end
        out_ready = 1'b0;
        check("frame_count", cap_n, N, 0);
        check("back_to_load_ready", int'(in_ready), 1, 0);
        check("back_to_load_valid", int'(out_valid), 0, 0);
    endtask

    initial begin
        int lat;
        vecs = '{
            '{0, 0, 1024, 0, 0}, '{0, 7, 1024, 0, 0}, '{0, 15, 1024, 0, 0},
            '{1, 0, 16384, 0, 1}, '{1, 1, 0, 0, 1}, '{1, 8, 0, 0, 1}, '{1, 15, 0, 0, 1},
            '{2, 1, 8192, 0, 3}, '{2, 0, 0, 0, 2}, '{2, 15, 0, 0, 2}, '{2, 9, 0, 0, 2},
            '{3, INV_BIN, 8192, 0, 3}, '{3, 16 - INV_BIN, 0, 0, 2}, '{3, 0, 0, 0, 2},
            '{3, 8, 0, 0, 2}, '{3, 4, 0, 0, 2}
        };
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("rst_in_ready", int'(in_ready), 1, 0);
        check("rst_out_valid", int'(out_valid), 0, 0);
        check("rst_out_last", int'(out_last), 0, 0);
        check("rst_busy", int'(busy), 0, 0);
        check("rst_out_re", int'(out_re), 0, 0);
        check("rst_out_im", int'(out_im), 0, 0);

        for (int f = 0; f < 4; f++) begin
            make_frame(f == 0 ? 0 : f == 1 ? 1 : 2, 0);
            run_frame(f == 3, 1'b0, lat);
            check("latency", lat, 33, 0);
            for (int b = 0; b < N; b++) begin
                res_re[f][b] = cap_re[b];
                res_im[f][b] = cap_im[b];
                check("last_flag", cap_last[b], b == N - 1 ? 1 : 0, 0);
            end
        end
        for (int b = 0; b < N; b++) begin
            check("impulse_re", res_re[0][b], 1024, 0);
            check("impulse_im", res_im[0][b], 0, 0);
        end
        foreach (vecs[i]) begin
            check($sformatf("vec%0d_re", i), res_re[vecs[i].frame][vecs[i].bin], vecs[i].exp_re, vecs[i].tol);
            check($sformatf("vec%0d_im", i), res_im[vecs[i].frame][vecs[i].bin], vecs[i].exp_im, vecs[i].tol);
        end

        // Impulse at n=1 gives a rotating output, so order and duplication show up.
        make_frame(0, 1);
        run_frame(1'b0, 1'b1, lat);
        for (int b = 0; b < N; b++) begin
            check("bp_re", cap_re[b], $rtoi($floor(1024.0 * $cos(TWO_PI * b / N) + 0.5)), 2);
            check("bp_im", cap_im[b], $rtoi($floor(-1024.0 * $sin(TWO_PI * b / N) + 0.5)), 2);
            check("bp_last", cap_last[b], b == N - 1 ? 1 : 0, 0);
        end

        make_frame(1, 0);
        drive_load(1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (9) @(negedge clk);
        check("busy_mid_compute", int'(busy), 1, 0);
        check("ready_mid_compute", int'(in_ready), 0, 0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_in_ready", int'(in_ready), 1, 0);
        check("abort_out_valid", int'(out_valid), 0, 0);
        check("abort_busy", int'(busy), 0, 0);
        make_frame(0, 0);
        run_frame(1'b0, 1'b0, lat);
        check("abort_latency", lat, 33, 0);
        for (int b = 0; b < N; b++) begin
            check("abort_imp_re", cap_re[b], 1024, 0);
            check("abort_imp_im", cap_im[b], 0, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
